// File: rtl/ag_ps2_keyb_pkg.sv
// ag_ps2_pkg: scan codes, Agat key codes, receiver state and keyboard mode flags
package ag_ps2_pkg;
    localparam logic [7:0] SC_E0 = 8'hE0, SC_F0 = 8'hF0, SC_E1 = 8'hE1, SC_AA = 8'hAA;
    localparam logic [7:0] SC_LSHIFT = 8'h12, SC_RSHIFT = 8'h59, SC_CTRL = 8'h14;
    localparam logic [7:0] SC_CAPS = 8'h58, SC_SCROLL = 8'h7E, SC_F12 = 8'h07;
    localparam logic [7:0] SC_SPACE = 8'h29, SC_ENTER = 8'h5A, SC_ESC = 8'h76, SC_BKSP = 8'h66;
    localparam logic [7:0] SC_LEFT = 8'h6B, SC_RIGHT = 8'h74, SC_UP = 8'h75, SC_DOWN = 8'h72;
    localparam logic [7:0] AG_BS = 8'h88, AG_RIGHT = 8'h95, AG_UP = 8'h99, AG_DOWN = 8'h9A;
    localparam logic [7:0] AG_CR = 8'h8D, AG_ESC = 8'h9B, AG_SPACE = 8'hA0;
    // set-2 make codes for A..Z and 0..9, in letter/digit order
    localparam logic [7:0] SC_LETTER [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
        8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] SC_DIGIT [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    typedef struct packed {
        logic ext;
        logic brk;
        logic shift;
        logic ctrl;
        logic rus;
        logic pause;
        logic rst;
    } kb_state_t;
endpackage

// File: rtl/ag_ps2_keyb_if.sv
// ag_ps2_keyb_if: filtered PS/2 lines and key_clear in, Agat key code and control lines out
interface ag_ps2_keyb_if;
    logic [1:0] ps2_bus;
    logic       key_clear;
    logic [7:0] key_reg;
    logic       key_rus;
    logic       key_rst;
    logic       key_pause;
    logic       frame_err;
    modport master (output ps2_bus, key_clear, input key_reg, key_rus, key_rst, key_pause, frame_err);
    modport slave (input ps2_bus, key_clear, output key_reg, key_rus, key_rst, key_pause, frame_err);
endinterface

// File: rtl/ag_ps2_keyb_rx.sv
// ag_ps2_rx: PS/2 device-to-host frame receiver with odd parity, stop check and idle timeout
module ag_ps2_rx
    import ag_ps2_pkg::*;
#(
    parameter int TIMEOUT = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ps2_bus,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    rx_state_e     state_q, state_d;
    logic [1:0]    s1_q, s2_q;
    logic          c3_q;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bit_q, bit_d;
    logic          par_q, par_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d, err_q, err_d;
    logic          fall, din, tout;

    assign fall = c3_q & ~s2_q[0];
    assign din = s2_q[1];
    assign tout = state_q != RX_IDLE && !fall && cnt_q == CW'(TIMEOUT - 1);
    assign rx_valid = valid_q;
    assign rx_data = sh_q;
    assign frame_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 2'b11;
            s2_q    <= 2'b11;
            c3_q    <= 1'b1;
            state_q <= RX_IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= ps2_bus;
            s2_q    <= s1_q;
            c3_q    <= s2_q[0];
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        par_d   = par_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = (state_q == RX_IDLE || fall) ? '0 : cnt_q + 1'b1;
        if (tout) begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    state_d = din ? RX_IDLE : RX_DATA;
                    err_d   = din;
                    bit_d   = '0;
                end
                RX_DATA: begin
                    sh_d    = {din, sh_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    state_d = bit_q == 3'd7 ? RX_PARITY : RX_DATA;
                end
                // parity verdict is held until the stop bit so a bad frame still ends cleanly
                RX_PARITY: begin
                    par_d   = ^{din, sh_q};
                    state_d = RX_STOP;
                end
                default: begin
                    valid_d = din & par_q;
                    err_d   = ~(din & par_q);
                    state_d = RX_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/ag_ps2_keyb.sv
// ag_ps2_keyb: PS/2 keyboard to Agat key register with prefix, modifier and control-line tracking
module ag_ps2_keyb
    import ag_ps2_pkg::*;
#(
    parameter int TIMEOUT = 2000
) (
    input logic           clk,
    input logic           reset,
    ag_ps2_keyb_if.slave  bus
);
    logic       rx_valid, frame_err;
    logic [7:0] rx_data, xl, key_q, key_d;
    kb_state_t  st_q, st_d;

    ag_ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk(clk),
        .reset(reset),
        .ps2_bus(bus.ps2_bus),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .frame_err(frame_err)
    );

    assign bus.key_reg = key_q;
    assign bus.key_rus = st_q.rus;
    assign bus.key_rst = st_q.rst;
    assign bus.key_pause = st_q.pause;
    assign bus.frame_err = frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= '0;
            key_q <= '0;
        end else begin
            st_q  <= st_d;
            key_q <= key_d;
        end
    end

    // every mapped code has bit 7 set, so xl[7] doubles as "mapped"
    always_comb begin
        xl = 8'h00;
        for (int i = 0; i < 26; i++)
            if (rx_data == SC_LETTER[i]) xl = (st_q.ctrl ? 8'h81 : st_q.rus ? 8'hE1 : 8'hC1) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (rx_data == SC_DIGIT[i]) xl = (st_q.shift && i != 0 ? 8'hA0 : 8'hB0) + 8'(i);
        case (rx_data)
            SC_SPACE: xl = AG_SPACE;
            SC_ENTER: xl = AG_CR;
            SC_ESC:   xl = AG_ESC;
            SC_BKSP:  xl = AG_BS;
            SC_LEFT:  xl = st_q.ext ? AG_BS : 8'h00;
            SC_RIGHT: xl = st_q.ext ? AG_RIGHT : 8'h00;
            SC_UP:    xl = st_q.ext ? AG_UP : 8'h00;
            SC_DOWN:  xl = st_q.ext ? AG_DOWN : 8'h00;
            default: ;
        endcase
    end

    always_comb begin
        st_d  = st_q;
        key_d = bus.key_clear ? {1'b0, key_q[6:0]} : key_q;
        if (rx_valid) begin
            if (rx_data == SC_E0) st_d.ext = 1'b1;
            else if (rx_data == SC_F0) st_d.brk = 1'b1;
            else if (rx_data != SC_E1 && rx_data != SC_AA) begin
                st_d.ext = 1'b0;
                st_d.brk = 1'b0;
                if (rx_data == SC_LSHIFT || rx_data == SC_RSHIFT) st_d.shift = !st_q.brk;
                if (rx_data == SC_CTRL) st_d.ctrl = !st_q.brk;
                if (rx_data == SC_F12) st_d.rst = !st_q.brk && (st_q.ctrl || st_q.rst);
                if (!st_q.brk) begin
                    st_d.rus   = st_q.rus ^ (rx_data == SC_CAPS);
                    st_d.pause = st_q.pause ^ (rx_data == SC_SCROLL);
                    if (xl[7]) key_d = xl;
                end
            end
        end
    end
endmodule

// File: tb/tb_ag_ps2_keyb.sv
// tb_ag_ps2_keyb: table vectors, hand sequences and randomized scan streams against a byte-level keyboard model
module tb_ag_ps2_keyb;
    localparam int TO = 100, HALF = 6, GAP = 10;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0, failures = 0, err_cnt = 0;

    ag_ps2_keyb_if bus ();
    ag_ps2_keyb #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(negedge clk) if (bus.frame_err === 1'b1) err_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
        8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] plain_sc [24] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h4D, 8'h15, 8'h16, 8'h1E, 8'h45,
        8'h46, 8'h29, 8'h5A, 8'h76, 8'h66, 8'h12, 8'h59, 8'h14, 8'h58, 8'h7E, 8'h07, 8'h6B, 8'h05,
        8'hE1, 8'hAA};
    logic [7:0] ext_sc [7] = '{8'h5A, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h14, 8'h7D};

    logic [7:0] letter_pos [logic [7:0]];
    logic [7:0] digit_val [logic [7:0]];
    logic [7:0] plain_map [logic [7:0]];
    logic [7:0] ext_map [logic [7:0]];

    logic [7:0] m_key;
    bit         m_rus, m_pause, m_rst, m_shift, m_ctrl, m_ext, m_brk;
    int         m_err;

    function automatic logic [7:0] agat_code(input logic [7:0] b);
        if (m_ext) return ext_map.exists(b) ? ext_map[b] : 8'h00;
        if (letter_pos.exists(b)) return (m_ctrl ? 8'h81 : m_rus ? 8'hE1 : 8'hC1) + letter_pos[b];
        if (digit_val.exists(b))
            return (m_shift && digit_val[b] != 8'd0) ? 8'hA0 + digit_val[b] : 8'hB0 + digit_val[b];
        return plain_map.exists(b) ? plain_map[b] : 8'h00;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] k;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b != 8'hE1 && b != 8'hAA) begin
            k = agat_code(b);
            if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
            if (b == 8'h14) m_ctrl = !m_brk;
            if (!m_brk) begin
                if (b == 8'h58) m_rus = !m_rus;
                if (b == 8'h7E) m_pause = !m_pause;
                if (b == 8'h07 && m_ctrl) m_rst = 1'b1;
                if (k != 8'h00) m_key = k;
            end else if (b == 8'h07) m_rst = 1'b0;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drives start..(nbits-1) and leaves the PS/2 clock low right after the last falling edge
    task automatic frame_to_stop(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_bus[1] = f[i];
            tick(HALF);
            bus.ps2_bus[0] = 1'b0;
            if (i < nbits - 1) begin
                tick(HALF);
                bus.ps2_bus[0] = 1'b1;
            end
        end
    endtask

    task automatic frame_end();
        tick(HALF);
        bus.ps2_bus = 2'b11;
        tick(GAP);
    endtask

    task automatic send_raw(input logic [7:0] b, input bit bad_par);
        frame_to_stop(b, bad_par, 11);
        frame_end();
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b, 1'b0);
    endtask

    task automatic put(input logic [7:0] b);
        send(b);
        model_byte(b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ps2_bus = 2'b11;
        bus.key_clear = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        m_key = 8'h00;
        {m_rus, m_pause, m_rst, m_shift, m_ctrl, m_ext, m_brk} = '0;
    endtask

    vec_t vt [18];

    initial begin
        int e0, w;
        vt[0]  = '{8'h1C, 8'h00, 8'h00, 1, 8'hC1};
        vt[1]  = '{8'h1A, 8'h00, 8'h00, 1, 8'hDA};
        vt[2]  = '{8'h45, 8'h00, 8'h00, 1, 8'hB0};
        vt[3]  = '{8'h46, 8'h00, 8'h00, 1, 8'hB9};
        vt[4]  = '{8'h29, 8'h00, 8'h00, 1, 8'hA0};
        vt[5]  = '{8'h5A, 8'h00, 8'h00, 1, 8'h8D};
        vt[6]  = '{8'h76, 8'h00, 8'h00, 1, 8'h9B};
        vt[7]  = '{8'h66, 8'h00, 8'h00, 1, 8'h88};
        vt[8]  = '{8'hE0, 8'h5A, 8'h00, 2, 8'h8D};
        vt[9]  = '{8'hE0, 8'h6B, 8'h00, 2, 8'h88};
        vt[10] = '{8'hE0, 8'h74, 8'h00, 2, 8'h95};
        vt[11] = '{8'hE0, 8'h75, 8'h00, 2, 8'h99};
        vt[12] = '{8'hE0, 8'h72, 8'h00, 2, 8'h9A};
        vt[13] = '{8'h12, 8'h16, 8'h00, 2, 8'hA1};
        vt[14] = '{8'h59, 8'h45, 8'h00, 2, 8'hB0};
        vt[15] = '{8'h14, 8'h1A, 8'h00, 2, 8'h9A};
        vt[16] = '{8'hE0, 8'h14, 8'h1C, 3, 8'h81};
        vt[17] = '{8'h12, 8'h1C, 8'h00, 2, 8'hC1};
        for (int i = 0; i < 26; i++) letter_pos[letter_sc[i]] = 8'(i);
        for (int i = 0; i < 10; i++) digit_val[digit_sc[i]] = 8'(i);
        plain_map[8'h29] = 8'hA0; plain_map[8'h5A] = 8'h8D;
        plain_map[8'h76] = 8'h9B; plain_map[8'h66] = 8'h88;
        ext_map[8'h5A] = 8'h8D; ext_map[8'h6B] = 8'h88; ext_map[8'h74] = 8'h95;
        ext_map[8'h75] = 8'h99; ext_map[8'h72] = 8'h9A;

        do_reset();
        chk("reset_outputs", {bus.key_reg, bus.key_rus, bus.key_rst, bus.key_pause, bus.frame_err}, 0);

        // end-to-end latency from the stop-bit edge, then key_clear
        frame_to_stop(8'h1C, 1'b0, 11);
        tick(3);
        chk("latency_3clk", bus.key_reg, 8'h00);
        tick(1);
        chk("latency_4clk", bus.key_reg, 8'hC1);
        frame_end();
        bus.key_clear = 1'b1;
        tick(1);
        bus.key_clear = 1'b0;
        chk("key_clear", bus.key_reg, 8'h41);

        foreach (vt[i]) begin
            do_reset();
            send(vt[i].b0);
            if (vt[i].nb > 1) send(vt[i].b1);
            if (vt[i].nb > 2) send(vt[i].b2);
            chk($sformatf("vec%0d", i), bus.key_reg, vt[i].exp);
        end

        do_reset();
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        chk("caps_rus", bus.key_rus, 1);
        chk("caps_letter", bus.key_reg, 8'hE1);
        send(8'h14); send(8'h1C);
        chk("ctrl_letter", bus.key_reg, 8'h81);

        do_reset();
        send(8'hE0); send(8'h75);
        chk("up_make", bus.key_reg, 8'h99);
        bus.key_clear = 1'b1;
        tick(1);
        bus.key_clear = 1'b0;
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_break_noload", bus.key_reg, 8'h19);
        send(8'hF0); send(8'h1C);
        chk("letter_break_noload", bus.key_reg, 8'h19);

        e0 = err_cnt;
        send_raw(8'h1C, 1'b1);
        chk("parity_err_pulse", err_cnt - e0, 1);
        chk("parity_err_noload", bus.key_reg, 8'h19);
        e0 = err_cnt;
        frame_to_stop(8'h16, 1'b0, 5);
        w = 0;
        while (err_cnt == e0 && w < TO + 50) begin
            tick(1);
            w++;
        end
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_window", w >= TO && w <= TO + 8, 1);
        bus.ps2_bus = 2'b11;
        tick(GAP);
        send(8'h16);
        chk("after_timeout", bus.key_reg, 8'hB1);
        chk("timeout_single", err_cnt - e0, 1);

        do_reset();
        send(8'h14); send(8'h07);
        chk("f12_rst_set", bus.key_rst, 1);
        send(8'hF0); send(8'h07);
        chk("f12_rst_clear", bus.key_rst, 0);
        send(8'h7E);
        chk("scroll_on", bus.key_pause, 1);
        send(8'hF0); send(8'h7E); send(8'h7E);
        chk("scroll_off", bus.key_pause, 0);

        bus.key_clear = 1'b1;
        frame_to_stop(8'h29, 1'b0, 11);
        tick(4);
        chk("load_beats_clear", bus.key_reg, 8'hA0);
        tick(1);
        chk("clear_after_load", bus.key_reg, 8'h20);
        bus.key_clear = 1'b0;
        frame_end();

        send(8'h58); send(8'h7E);
        e0 = err_cnt;
        frame_to_stop(8'h1C, 1'b0, 6);
        reset = 1'b1;
        tick(2);
        bus.ps2_bus = 2'b11;
        tick(2);
        reset = 1'b0;
        tick(2);
        chk("midframe_reset_out", {bus.key_reg, bus.key_rus, bus.key_rst, bus.key_pause, bus.frame_err}, 0);
        chk("midframe_reset_noerr", err_cnt - e0, 0);
        send(8'h1C);
        chk("after_midframe_reset", bus.key_reg, 8'hC1);

        do_reset();
        m_err = 0;
        e0 = err_cnt;
        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            logic [7:0] p, e;
            kind = $urandom_range(0, 9);
            p = plain_sc[$urandom_range(0, 23)];
            e = ext_sc[$urandom_range(0, 6)];
            if (kind <= 4) put(p);
            else if (kind == 5) begin put(8'hF0); put(p); end
            else if (kind == 6) begin put(8'hE0); put(e); end
            else if (kind == 7) begin put(8'hE0); put(8'hF0); put(e); end
            else if (kind == 8) begin send_raw(p, 1'b1); m_err++; end
            else begin
                bus.key_clear = 1'b1;
                tick(1);
                bus.key_clear = 1'b0;
                m_key[7] = 1'b0;
            end
            chk($sformatf("random%0d", n), {bus.key_reg, bus.key_rus, bus.key_pause, bus.key_rst},
                {m_key, m_rus, m_pause, m_rst});
        end
        chk("random_errors", err_cnt - e0, m_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
